// File: rtl/align_requant_pkg.sv
// align_pkg: shared constants, the S1->S2 stage record and the binary-point
// difference helper used by align_requant.
package align_pkg;

    localparam int OPBP_W     = 5;
    localparam int RSBP_W     = 4;
    localparam int MAX_LSHIFT = 15;
    // Wide enough for IN_W + MAX_LSHIFT with IN_W up to 49.
    localparam int EXT_W      = 64;

    typedef struct packed {
        logic                    valid;
        logic signed [EXT_W-1:0] value;
        logic                    rnd;
    } stage_t;

    function automatic logic signed [6:0] bp_diff(
        input logic [OPBP_W-1:0] opbp,
        input logic [RSBP_W-1:0] rsbp
    );
        return signed'({2'b00, opbp}) - signed'({3'b000, rsbp});
    endfunction

endpackage

// File: rtl/align_requant_sat.sv
// align_sat: adds the rounding increment to an aligned value and clamps it
// to the signed OUT_W range. Rounding is built only with ALIGN_ROUND_EN.
module align_sat #(
    parameter int W     = 64,
    parameter int OUT_W = 8
) (
    input  logic signed [W-1:0] i_value,
    input  logic                i_rnd,
    output logic [OUT_W-1:0]    o_data,
    output logic                o_sat
);

    localparam logic signed [W-1:0] W_MAX = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [W-1:0] W_MIN = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [W-1:0] w_sum;
    logic                w_hi;
    logic                w_lo;

`ifdef ALIGN_ROUND_EN
    assign w_sum = i_value + W'(i_rnd);
`else
    logic w_unused_rnd;
    assign w_unused_rnd = i_rnd;
    assign w_sum        = i_value;
`endif

    assign w_hi   = w_sum > W_MAX;
    assign w_lo   = w_sum < W_MIN;
    assign o_sat  = w_hi || w_lo;
    assign o_data = w_hi ? W_MAX[OUT_W-1:0] : w_lo ? W_MIN[OUT_W-1:0] : w_sum[OUT_W-1:0];

endmodule

// File: rtl/align_requant.sv
// align_requant: re-aligns a signed sample between binary points and requantises
// it to OUT_W bits (S1 shift, S2 round/saturate). ALIGN_ROUND_EN enables rounding.
module align_requant
    import align_pkg::*;
#(
    parameter int IN_W  = 24,
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [OPBP_W-1:0] in_opbp,
    input  logic [RSBP_W-1:0] in_rsbp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat,
    output logic [CNT_W-1:0]  sat_cnt,
    input  logic              sat_clr
);

    stage_t                  r_s1;
    logic                    r_s2_valid;
    logic [OUT_W-1:0]        r_out_data;
    logic                    r_out_sat;
    logic [CNT_W-1:0]        r_sat_cnt;

    logic signed [6:0]       w_d;
    logic                    w_neg;
    logic [4:0]              w_amt;
    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_shifted;
    logic                    w_rnd;
    logic                    w_s1_load;
    logic                    w_s2_load;
    logic [OUT_W-1:0]        w_sat_data;
    logic                    w_sat;

    assign w_d       = bp_diff(in_opbp, in_rsbp);
    assign w_neg     = w_d[6];
    assign w_amt     = 5'(w_neg ? -w_d : w_d);
    assign w_ext     = {{(EXT_W-IN_W){in_data[IN_W-1]}}, in_data};
    // The wide arithmetic shift gives sign fill for right shifts of IN_W or more.
    assign w_shifted = w_neg ? (w_ext <<< w_amt) : (w_ext >>> w_amt);

`ifdef ALIGN_ROUND_EN
    logic [5:0] w_ridx;
    assign w_ridx = {1'b0, w_amt} - 6'd1;
    assign w_rnd  = !w_neg && (w_amt != 5'd0) && w_ext[w_ridx];
`else
    assign w_rnd  = 1'b0;
`endif

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1.valid || w_s2_load;
    assign in_ready  = w_s1_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_s1 <= '0;
        else if (w_s1_load)
            r_s1 <= '{valid: in_valid, value: w_shifted, rnd: w_rnd};
    end

    align_sat #(
        .W     (EXT_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .i_value (r_s1.value),
        .i_rnd   (r_s1.rnd),
        .o_data  (w_sat_data),
        .o_sat   (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1.valid;
            if (r_s1.valid) begin
                r_out_data <= w_sat_data;
                r_out_sat  <= w_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sat_cnt <= '0;
        else if (sat_clr)
            r_sat_cnt <= '0;
        else if (r_s2_valid && out_ready && r_out_sat && !(&r_sat_cnt))
            r_sat_cnt <= r_sat_cnt + CNT_W'(1);
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_align_requant.sv
// tb_align_requant: directed vectors for align_requant with hand-computed results,
// covering both the truncating and the ALIGN_ROUND_EN build.
module tb_align_requant;

`ifdef ALIGN_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = '0;
    logic [4:0]  in_opbp = '0;
    logic [3:0]  in_rsbp = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_sat;
    logic [3:0]  sat_cnt;
    logic        sat_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    align_requant #(
        .IN_W  (24),
        .OUT_W (8),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_opbp   (in_opbp),
        .in_rsbp   (in_rsbp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_cnt   (sat_cnt),
        .sat_clr   (sat_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_one(input string tag, input logic [23:0] d, input logic [4:0] op,
                            input logic [3:0] rs, input logic [7:0] exp_d, input logic exp_s,
                            input logic clr);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_opbp   = op;
        in_rsbp   = rs;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".lat"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, ".vld"}, 32'(out_valid), 32'd1);
        check({tag, ".dat"}, 32'(out_data), 32'(exp_d));
        check({tag, ".sat"}, 32'(out_sat), 32'(exp_s));
        sat_clr = clr;
        if (clr)
            exp_cnt = 0;
        else if (exp_s && exp_cnt != 15)
            exp_cnt++;
        @(negedge clk);
        sat_clr = 1'b0;
        check({tag, ".cnt"}, 32'(sat_cnt), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int  sent;
        int  rcv;
        int  infl;
        bit  saw_full;
        bit  prev_stall;
        logic [7:0] held;

        #12;
        check("rst.vld", 32'(out_valid), 32'd0);
        check("rst.dat", 32'(out_data), 32'd0);
        check("rst.sat", 32'(out_sat), 32'd0);
        check("rst.cnt", 32'(sat_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.rdy", 32'(in_ready), 32'd1);

        send_one("v01", 24'h000180,  8,  0, RND ? 8'h02 : 8'h01, 1'b0, 1'b0);
        send_one("v02", 24'h7FFFFF,  0,  4, 8'h7F, 1'b1, 1'b0);
        send_one("v03", 24'hFFFFFD, 31,  0, RND ? 8'h00 : 8'hFF, 1'b0, 1'b0);
        send_one("v04", 24'h800000,  0,  0, 8'h80, 1'b1, 1'b0);
        send_one("v05", 24'h00007F,  0,  0, 8'h7F, 1'b0, 1'b0);
        send_one("v06", 24'hFFFF80,  0,  0, 8'h80, 1'b0, 1'b0);
        send_one("v07", 24'h000080,  0,  0, 8'h7F, 1'b1, 1'b0);
        send_one("v08", 24'h000005,  0,  3, 8'h28, 1'b0, 1'b0);
        send_one("v09", 24'h000005,  1,  0, RND ? 8'h03 : 8'h02, 1'b0, 1'b0);
        send_one("v10", 24'hFFFFFB,  1,  0, RND ? 8'hFE : 8'hFD, 1'b0, 1'b0);
        send_one("v11", 24'h000010,  0, 15, 8'h7F, 1'b1, 1'b0);
        send_one("v12", 24'hFFFFFF,  0, 15, 8'h80, 1'b1, 1'b0);
        send_one("v13", 24'h7FFFFF, 31, 15, 8'h7F, RND, 1'b0);
        send_one("v14", 24'h7FFFFF, 24,  0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++)
            send_one("cntsat", 24'h800000, 0, 0, 8'h80, 1'b1, 1'b0);
        check("cnt.max", 32'(sat_cnt), 32'd15);
        send_one("cntclr", 24'h800000, 0, 0, 8'h80, 1'b1, 1'b1);

        // Stream with a four-cycle downstream stall.
        sent = 0;
        rcv = 0;
        saw_full = 1'b0;
        prev_stall = 1'b0;
        held = '0;
        for (int c = 0; c < 60 && rcv < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = sent < 8;
            in_data   = 24'(sent * 3);
            in_opbp   = '0;
            in_rsbp   = '0;
            #1;
            infl = sent - rcv;
            check("strm.rdy", 32'(in_ready),
                  32'(!(out_valid && !out_ready && (infl - int'(out_valid)) > 0)));
            if (prev_stall)
                check("strm.hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, held});
            if (!in_ready)
                saw_full = 1'b1;
            prev_stall = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                check("strm.dat", 32'(out_data), 32'(8'(rcv * 3)));
                rcv++;
            end
            if (in_valid && in_ready)
                sent++;
        end
        in_valid = 1'b0;
        check("strm.cnt", 32'(rcv), 32'd8);
        check("strm.full", 32'(saw_full), 32'd1);

        // Asynchronous reset with both stages occupied.
        send_one("pre", 24'h7FFFFF, 0, 4, 8'h7F, 1'b1, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 24'h000011;
        in_opbp   = '0;
        in_rsbp   = '0;
        @(negedge clk);
        in_data = 24'h000022;
        @(negedge clk);
        in_valid = 1'b0;
        check("full.vld", 32'(out_valid), 32'd1);
        check("full.rdy", 32'(in_ready), 32'd0);
        check("full.dat", 32'(out_data), 32'h11);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.vld", 32'(out_valid), 32'd0);
        check("arst.dat", 32'(out_data), 32'd0);
        check("arst.cnt", 32'(sat_cnt), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post.vld", 32'(out_valid), 32'd0);
        end
        check("post.rdy", 32'(in_ready), 32'd1);
        send_one("post", 24'h000180, 8, 0, RND ? 8'h02 : 8'h01, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
